// File: rtl/data_cache_stage.sv
// Memory stage: direct-mapped write-back data cache with 128-bit line refill/eviction handshake.
// Optional byte loads/stores are enabled by defining CACHE_BYTE_ACCESS_EN.
module data_cache_stage #(
    parameter int LINES = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         kill_i,
    input  logic         a_valid_i,
    input  logic         a_is_load_i,
    input  logic         a_is_store_i,
`ifdef CACHE_BYTE_ACCESS_EN
    input  logic         a_byte_i,
`endif
    input  logic [31:0]  a_addr_i,
    input  logic [31:0]  a_store_data_i,
    input  logic [31:0]  a_alu_result_i,
    input  logic         a_reg_write_enable_i,
    input  logic [31:0]  a_write_addr_i,
    output logic [31:0]  c_data_o,
    output logic         c_reg_write_enable_o,
    output logic [31:0]  c_write_addr_o,
    output logic         stall_core_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_wdata_o,
    input  logic [127:0] mem_rdata_i,
    input  logic         mem_ready_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       data_q [LINES];
    logic [27:0]        line_q;
    logic [31:0]        mem_addr_q;
    logic [127:0]       mem_wdata_q;

    logic [IDX_W-1:0]   idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               mem_op, hit, miss, store_hit, victim_dirty, fill_done;
    logic [127:0]       line;
    logic [31:0]        word, load_data;

`ifdef CACHE_BYTE_ACCESS_EN
    function automatic logic [31:0] sext8(input logic signed [7:0] b);
        logic signed [31:0] w;
        w = b;
        return w;
    endfunction
`endif

    assign idx          = a_addr_i[IDX_W+3:4];
    assign tag          = a_addr_i[31:IDX_W+4];
    assign fill_idx     = line_q[IDX_W-1:0];
    assign fill_tag     = line_q[27:IDX_W];
    assign line         = data_q[idx];
    assign word         = line[{a_addr_i[3:2], 5'b00000} +: 32];

    assign mem_op       = a_valid_i & (a_is_load_i | a_is_store_i) & ~kill_i;
    assign hit          = valid_q[idx] && (tag_q[idx] == tag);
    assign miss         = (state_q == IDLE) & mem_op & ~hit;
    assign store_hit    = (state_q == IDLE) & mem_op & hit & a_is_store_i;
    assign victim_dirty = valid_q[idx] & dirty_q[idx];
    assign fill_done    = (state_q == REFILL) & mem_ready_i;

`ifdef CACHE_BYTE_ACCESS_EN
    assign load_data = a_byte_i ? sext8(line[{a_addr_i[3:0], 3'b000} +: 8]) : word;
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^a_addr_i[1:0];
    assign load_data       = word;
`endif

    assign c_data_o             = (a_valid_i & a_is_load_i) ? load_data : a_alu_result_i;
    assign c_reg_write_enable_o = a_reg_write_enable_i & ~kill_i;
    assign c_write_addr_o       = a_write_addr_i;
    assign stall_core_o         = (state_q != IDLE) | miss;

    // Request outputs decode only registered state, never the a_* inputs.
    assign mem_req_o   = (state_q != IDLE);
    assign mem_we_o    = (state_q == WRITEBACK);
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (miss) state_d = victim_dirty ? WRITEBACK : REFILL;
            WRITEBACK: if (mem_ready_i) state_d = REFILL;
            REFILL:    if (mem_ready_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            line_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        line_q <= a_addr_i[31:4];
                        if (victim_dirty) begin
                            mem_addr_q  <= {tag_q[idx], idx, 4'b0000};
                            mem_wdata_q <= data_q[idx];
                        end else begin
                            mem_addr_q  <= {a_addr_i[31:4], 4'b0000};
                        end
                    end else if (store_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready_i) begin
                        mem_addr_q  <= {line_q, 4'b0000};
                        mem_wdata_q <= '0;
                    end
                end
                REFILL: begin
                    if (mem_ready_i) begin
                        valid_q[fill_idx] <= 1'b1;
                        dirty_q[fill_idx] <= 1'b0;
                        mem_addr_q        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; valid bits gate its use.
    always_ff @(posedge clk_i) begin
        if (fill_done) begin
            data_q[fill_idx] <= mem_rdata_i;
            tag_q[fill_idx]  <= fill_tag;
        end else if (store_hit) begin
`ifdef CACHE_BYTE_ACCESS_EN
            if (a_byte_i)
                data_q[idx][{a_addr_i[3:0], 3'b000} +: 8] <= a_store_data_i[7:0];
            else
                data_q[idx][{a_addr_i[3:2], 5'b00000} +: 32] <= a_store_data_i;
`else
            data_q[idx][{a_addr_i[3:2], 5'b00000} +: 32] <= a_store_data_i;
`endif
        end
    end

endmodule
